// File: rtl/vga_pkg.sv
// Shared VGA 640x480 timing constants and the decoder state type.
// Imported by the sync decoder and its period meters.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = 800;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = 525;

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } decState_t;

endpackage

// File: rtl/vga_period_meter.sv
// Sync edge detector with saturating period counter and
// a latch holding the last completed period.
module vga_period_meter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         sync_i,
  input  logic         inc_i,
  output logic         edge_o,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] meas_o
);

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] MAX = '1;

  logic         prev_q;
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W-1:0] meas_q;
  logic [W-1:0] meas_d;

  assign edge_o = sync_i & ~prev_q;
  assign cnt_o  = cnt_q;
  assign meas_o = meas_q;

  // On an edge the counter restarts, counting this
  // cycle's increment as the first unit of the new period.
  always_comb begin
    cnt_d  = cnt_q;
    meas_d = meas_q;
    if (edge_o) begin
      meas_d = cnt_q;
      cnt_d  = inc_i ? ONE : '0;
    end else if (inc_i && cnt_q != MAX) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      meas_q <= '0;
    end else begin
      prev_q <= sync_i;
      cnt_q  <= cnt_d;
      meas_q <= meas_d;
    end
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// VGA receive front end: measures line/frame timing, locks,
// and emits active pixels with recovered coordinates.
module vga_sync_decoder #(
  parameter int H_ACTIVE        = vga_pkg::H_ACTIVE,
  parameter int H_TOTAL         = vga_pkg::H_TOTAL,
  parameter int V_ACTIVE        = vga_pkg::V_ACTIVE,
  parameter int V_TOTAL         = vga_pkg::V_TOTAL,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        hSync,
  input  logic        vSync,
  input  logic        blankB,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  output logic        pixValid,
  output logic [9:0]  pixX,
  output logic [9:0]  pixY,
  output logic [3:0]  pixR,
  output logic [3:0]  pixG,
  output logic [3:0]  pixB,
  output logic        frameStart,
  output logic        lineStart,
  output logic        locked,
  output logic        timingErr,
  output logic [10:0] hTotalMeas,
  output logic [9:0]  vTotalMeas
);

  import vga_pkg::*;

  localparam logic [10:0] HT  = 11'(H_TOTAL);
  localparam logic [9:0]  HA  = 10'(H_ACTIVE);
  localparam logic [9:0]  VA  = 10'(V_ACTIVE);
  localparam logic [9:0]  VT  = 10'(V_TOTAL);
  localparam logic [3:0]  LF  = 4'(LOCK_FRAMES);
  localparam logic [9:0]  ONE = 10'd1;

  logic       hs_q, hs_d, vs_q, vs_d;
  logic       blank_q;
  logic [3:0] r_q, g_q, b_q;

  always_comb begin
    hs_d = (SYNC_ACTIVE_LOW != 0) ? ~hSync : hSync;
    vs_d = (SYNC_ACTIVE_LOW != 0) ? ~vSync : vSync;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      blank_q <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blankB;
      r_q     <= r;
      g_q     <= g;
      b_q     <= b;
    end
  end

  logic        h_edge, v_edge, h_sat;
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;

  vga_period_meter #(.W(11)) u_line (
    .clk    (clk),
    .nrst   (nrst),
    .sync_i (hs_q),
    .inc_i  (1'b1),
    .edge_o (h_edge),
    .cnt_o  (h_cnt),
    .meas_o (hTotalMeas)
  );

  vga_period_meter #(.W(10)) u_frame (
    .clk    (clk),
    .nrst   (nrst),
    .sync_i (vs_q),
    .inc_i  (h_edge),
    .edge_o (v_edge),
    .cnt_o  (v_cnt),
    .meas_o (vTotalMeas)
  );

  assign h_sat = h_cnt == 11'h7FF;

  decState_t  state_q;
  logic [3:0] good_q, good_inc;
  logic [9:0] x_q, x_d, y_q, y_d, y_inc;
  logic       bad_q, bad_d;
  logic       line_act, line_bad, pix_ovr;
  logic       frame_good, pv;

  // The line closes before the frame when both edges coincide.
  always_comb begin
    line_act = x_q != '0;
    x_d = x_q;
    if (h_edge) x_d = '0;
    else if (blank_q && x_q != '1) x_d = x_q + ONE;
    y_inc = y_q;
    if (h_edge && line_act && y_q != '1) y_inc = y_q + ONE;
    y_d = v_edge ? '0 : y_inc;
    line_bad = h_edge &&
      (h_cnt != HT || (line_act && x_q != HA));
    pix_ovr = blank_q && (x_q >= HA || y_q >= VA);
    frame_good = !(bad_q || line_bad || pix_ovr) &&
      v_cnt == VT && y_inc == VA;
    bad_d = v_edge ? 1'b0 : (bad_q | line_bad | pix_ovr);
    good_inc = good_q + 4'd1;
    pv = blank_q && state_q == LOCKED && x_q < HA && y_q < VA;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      x_q   <= '0;
      y_q   <= '0;
      bad_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      bad_q <= bad_d;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= SEARCH;
      good_q    <= '0;
      timingErr <= 1'b0;
    end else begin
      timingErr <= 1'b0;
      unique case (state_q)
        SEARCH: begin
          if (v_edge && !h_sat) begin
            state_q <= ACQUIRE;
            good_q  <= '0;
          end
        end
        ACQUIRE: begin
          if (h_sat) begin
            state_q <= SEARCH;
          end else if (v_edge) begin
            if (!frame_good) begin
              good_q <= '0;
            end else begin
              good_q <= good_inc;
              if (good_inc == LF) state_q <= LOCKED;
            end
          end
        end
        LOCKED: begin
          if (h_sat || (h_edge && h_cnt != HT) ||
              (v_edge && v_cnt != VT)) begin
            timingErr <= 1'b1;
            state_q   <= ACQUIRE;
            good_q    <= '0;
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  assign locked = state_q == LOCKED;

  logic       pv_d, fs_d, ls_d;
  logic [9:0] px_d, py_d;
  logic [3:0] pr_d, pg_d, pb_d;

  always_comb begin
    pv_d = pv;
    fs_d = pv && x_q == '0 && y_q == '0;
    ls_d = pv && x_q == '0;
    px_d = pv ? x_q : pixX;
    py_d = pv ? y_q : pixY;
    pr_d = pv ? r_q : pixR;
    pg_d = pv ? g_q : pixG;
    pb_d = pv ? b_q : pixB;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pixValid   <= 1'b0;
      frameStart <= 1'b0;
      lineStart  <= 1'b0;
      pixX       <= '0;
      pixY       <= '0;
      pixR       <= '0;
      pixG       <= '0;
      pixB       <= '0;
    end else begin
      pixValid   <= pv_d;
      frameStart <= fs_d;
      lineStart  <= ls_d;
      pixX       <= px_d;
      pixY       <= py_d;
      pixR       <= pr_d;
      pixG       <= pg_d;
      pixB       <= pb_d;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced 8x6 mode
// (16 clocks/line, 10 lines/frame, negative syncs).
module tb_vga_sync_decoder;

  localparam int HA = 8;
  localparam int HT = 16;
  localparam int VA = 6;
  localparam int VT = 10;

  logic        clk = 1'b0;
  logic        nrst;
  logic        hSync, vSync, blankB;
  logic [3:0]  r, g, b;
  logic        pixValid, frameStart, lineStart;
  logic        locked, timingErr;
  logic [9:0]  pixX, pixY;
  logic [3:0]  pixR, pixG, pixB;
  logic [10:0] hTotalMeas;
  logic [9:0]  vTotalMeas;

  vga_sync_decoder #(
    .H_ACTIVE        (HA),
    .H_TOTAL         (HT),
    .V_ACTIVE        (VA),
    .V_TOTAL         (VT),
    .SYNC_ACTIVE_LOW (1),
    .LOCK_FRAMES     (2)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .hSync      (hSync),
    .vSync      (vSync),
    .blankB     (blankB),
    .r          (r),
    .g          (g),
    .b          (b),
    .pixValid   (pixValid),
    .pixX       (pixX),
    .pixY       (pixY),
    .pixR       (pixR),
    .pixG       (pixG),
    .pixB       (pixB),
    .frameStart (frameStart),
    .lineStart  (lineStart),
    .locked     (locked),
    .timingErr  (timingErr),
    .hTotalMeas (hTotalMeas),
    .vTotalMeas (vTotalMeas)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pv_cnt = 0, fs_cnt = 0, ls_cnt = 0;
  int te_cnt = 0, mon_err = 0;
  int pv_b, fs_b, ls_b, te_b;

  logic [9:0] drv_x, drv_y, d1_x, d1_y, d2_x, d2_y;
  logic       drv_act, d1_act, d2_act;

  initial begin
    drv_x = '0; drv_y = '0; drv_act = 1'b0;
  end

  always @(posedge clk) begin
    d1_x <= drv_x; d1_y <= drv_y; d1_act <= drv_act;
    d2_x <= d1_x;  d2_y <= d1_y;  d2_act <= d1_act;
  end

  always @(posedge clk) begin
    #1;
    if (timingErr) te_cnt++;
    if (pixValid) begin
      pv_cnt++;
      if (!(d2_act && pixX === d2_x && pixY === d2_y &&
            pixR === d2_x[3:0] && pixG === d2_y[3:0] &&
            pixB === d2_x[7:4]))
        mon_err++;
    end
    if (frameStart) begin
      fs_cnt++;
      if (!(pixValid && d2_x == 0 && d2_y == 0)) mon_err++;
    end
    if (lineStart) begin
      ls_cnt++;
      if (!(pixValid && d2_x == 0)) mon_err++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int vc, input int hc);
    logic [9:0] xb, yb;
    logic act;
    xb = 10'(hc);
    yb = 10'(vc);
    act = hc < HA && vc < VA;
    hSync  = !(hc >= 10 && hc < 12);
    vSync  = !(vc >= 7 && vc < 9);
    blankB = act;
    r = xb[3:0];
    g = yb[3:0];
    b = xb[7:4];
    drv_x = xb; drv_y = yb; drv_act = act;
    @(negedge clk);
  endtask

  task automatic span(input int vc, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) step(vc, h);
  endtask

  task automatic frame(input int nl, input int short_l);
    for (int v = 0; v < nl; v++)
      span(v, 0, (v == short_l) ? HT - 2 : HT - 1);
  endtask

  task automatic lines(input int v0, input int v1);
    for (int v = v0; v <= v1; v++) span(v, 0, HT - 1);
  endtask

  task automatic snap();
    pv_b = pv_cnt; fs_b = fs_cnt; ls_b = ls_cnt; te_b = te_cnt;
  endtask

  initial begin
    nrst = 1'b0;
    hSync = 1'b1; vSync = 1'b1; blankB = 1'b0;
    r = '0; g = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_locked", locked, 0);
    chk("rst_pixValid", pixValid, 0);
    chk("rst_timingErr", timingErr, 0);
    chk("rst_hTotalMeas", hTotalMeas, 0);
    chk("rst_vTotalMeas", vTotalMeas, 0);
    chk("rst_pixX", pixX, 0);
    nrst = 1'b1;

    // Clean timing: lock two clocks after the 3rd vSync edge.
    frame(VT, -1);
    frame(VT, -1);
    lines(0, 6);
    chk("lock_before", locked, 0);
    step(7, 0);
    chk("lock_p1", locked, 0);
    step(7, 1);
    chk("lock_p2", locked, 1);
    span(7, 2, HT - 1);
    lines(8, 9);

    // One locked frame of pixels.
    snap();
    frame(VT, -1);
    chk("frm_pixels", pv_cnt - pv_b, HA * VA);
    chk("frm_frameStart", fs_cnt - fs_b, 1);
    chk("frm_lineStart", ls_cnt - ls_b, VA);
    chk("frm_pixel_data", mon_err, 0);
    chk("frm_last_x", pixX, HA - 1);
    chk("frm_last_y", pixY, VA - 1);
    chk("frm_last_r", pixR, 7);
    chk("frm_last_g", pixG, 5);
    chk("frm_last_b", pixB, 0);
    chk("frm_hmeas", hTotalMeas, HT);
    chk("frm_vmeas", vTotalMeas, VT);

    // Line 2 shortened to HT-1 while locked.
    snap();
    lines(0, 1);
    span(2, 0, HT - 2);
    span(3, 0, 10);
    chk("short_err_pre", timingErr, 0);
    step(3, 11);
    chk("short_err", timingErr, 1);
    chk("short_unlock", locked, 0);
    chk("short_hmeas", hTotalMeas, HT - 1);
    step(3, 12);
    chk("short_err_clr", timingErr, 0);
    span(3, 13, HT - 1);
    lines(4, 9);

    // A short frame during acquisition resets the good count.
    frame(VT - 1, -1);
    lines(0, 7);
    chk("shortfrm_vmeas", vTotalMeas, VT - 1);
    lines(8, 9);
    frame(VT, -1);
    chk("shortfrm_nolock", locked, 0);
    lines(0, 6);
    step(7, 0);
    chk("relock_p1", locked, 0);
    step(7, 1);
    chk("relock_p2", locked, 1);
    chk("relock_err_once", te_cnt - te_b, 1);
    span(7, 2, HT - 1);
    lines(8, 9);

    // hSync missing long enough to saturate the line counter.
    snap();
    for (int i = 0; i < 2100; i++) step(9, 15);
    chk("sat_err_once", te_cnt - te_b, 1);
    chk("sat_unlock", locked, 0);
    span(0, 0, 11);
    chk("sat_hmeas", hTotalMeas, 2047);
    span(0, 12, HT - 1);
    lines(1, 9);
    frame(VT, -1);
    lines(0, 6);
    step(7, 0);
    chk("sat_relock_p1", locked, 0);
    step(7, 1);
    chk("sat_relock_p2", locked, 1);
    span(7, 2, HT - 1);
    lines(8, 9);

    // Reset pulse mid-line while locked.
    lines(0, 2);
    span(3, 0, 3);
    chk("pre_rst_valid", pixValid, 1);
    #2 nrst = 1'b0;
    #1;
    chk("mid_rst_valid", pixValid, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_x", pixX, 0);
    chk("mid_rst_y", pixY, 0);
    chk("mid_rst_r", pixR, 0);
    chk("mid_rst_hmeas", hTotalMeas, 0);
    chk("mid_rst_vmeas", vTotalMeas, 0);
    nrst = 1'b1;
    snap();
    span(3, 4, HT - 1);
    lines(4, 9);
    frame(VT, -1);
    lines(0, 6);
    step(7, 0);
    chk("rst_relock_p1", locked, 0);
    step(7, 1);
    chk("rst_relock_p2", locked, 1);
    chk("rst_no_pixels", pv_cnt - pv_b, 0);
    span(7, 2, HT - 1);
    lines(8, 9);
    snap();
    frame(VT, -1);
    chk("rst_frm_pixels", pv_cnt - pv_b, HA * VA);
    chk("rst_frm_fs", fs_cnt - fs_b, 1);
    chk("rst_frm_ls", ls_cnt - ls_b, VA);
    chk("final_pixel_data", mon_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA timing generator. It samples the hSync/vSync/blankB/RGB bundle in the pixel clock domain and measures line and frame periods against the nominal mode. Once it has locked, it emits each active pixel with recovered (x, y) coordinates and frame/line strobes. In the edge-detection pipeline it serves as the video capture front end and as a loop-back checker for the generator.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 800, clocks per line
- V_ACTIVE, 480, active lines per frame
- V_TOTAL, 525, lines per frame
- SYNC_ACTIVE_LOW, 1, sync pulse polarity (1 = negative)
- LOCK_FRAMES, 2, consecutive good frames required to lock
- clk  in  1  pixel clock; all logic on rising edge
- nrst  in  1  reset, asynchronous, active-low
- hSync, vSync  in  1  sync inputs
- blankB  in  1  high = active video
- r, g, b  in  4 each  pixel colour
- pixValid  out  1  active pixel present, decoder locked
- pixX  out  10  column 0..H_ACTIVE-1
- pixY  out  10  row 0..V_ACTIVE-1
- pixR, pixG, pixB  out  4 each  registered colour
- frameStart  out  1  one-cycle pulse with pixel (0,0)
- lineStart  out  1  one-cycle pulse with pixel x=0
- locked  out  1  in LOCKED state
- timingErr  out  1  one-cycle pulse on any period mismatch
- hTotalMeas  out  11  last measured line length in clocks
- vTotalMeas  out  10  last measured frame length in lines

## Operation
- Stage 1 registers all inputs. Sync signals are normalised to active-high (inverted when SYNC_ACTIVE_LOW). A leading edge is defined as current=1 and previous=0.
- hCnt (11 b) is cleared to 1 on an hSync leading edge and otherwise increments, saturating at 2047. On each edge the previous value is latched into hTotalMeas.
- vCnt (10 b) increments on each hSync edge and is cleared on a vSync edge. The old value is latched into vTotalMeas.
- hSync and vSync edges in the same cycle: process the line first, then the frame.
- xCnt increments for each cycle with blankB high and is cleared on an hSync edge.
- yCnt increments on each hSync edge that ends a line containing ≥1 active pixel, and is cleared on a vSync edge.
- A frame is good when all of the following hold:
  - every hTotalMeas in the frame equals H_TOTAL;
  - vTotalMeas equals V_TOTAL;
  - every active line has exactly H_ACTIVE pixels;
  - the frame has exactly V_ACTIVE active lines.
- State machine:
  - SEARCH → ACQUIRE on the first vSync edge; clear goodCnt.
  - ACQUIRE: on each vSync edge, a good frame increments goodCnt; a bad frame clears it. goodCnt == LOCK_FRAMES → LOCKED.
  - LOCKED: any hTotalMeas ≠ H_TOTAL at an hSync edge, vTotalMeas ≠ V_TOTAL at a vSync edge, or hCnt saturation → pulse timingErr, go to ACQUIRE, clear goodCnt.
  - In SEARCH or ACQUIRE, hCnt saturation (no hSync) → SEARCH.
- pixValid = stage-1 blankB & LOCKED & xCnt < H_ACTIVE & yCnt < V_ACTIVE. Overrun pixels are dropped and flag the frame bad.
- pixR/G/B, pixX, and pixY are updated only when pixValid is high and otherwise hold their last value.

## Timing
- Reset values:
  - every output is 0;
  - state is SEARCH;
  - all counters, goodCnt, and the edge-history registers are 0.
- Latency: a pixel on the input pins appears on the pix* outputs 2 clocks later (stage 1 plus output register). frameStart and lineStart are aligned with pixValid.
- Lock: asserted at the LOCK_FRAMES-th good vSync edge after the first vSync edge. For the defaults this is 3 vSync edges after reset release. locked rises 2 clocks after that vSync pin edge.
- timingErr is asserted in the same cycle that locked falls.
- Asserting reset mid-frame clears everything asynchronously. Relock then requires full frames again.
- No backpressure: the consumer must accept one pixel per clock.

## Structure
- Package vga_pkg holds:
  - the default 640×480 constants (H_ACTIVE, H_TOTAL, V_ACTIVE, V_TOTAL, and porch/sync widths shared with the generator);
  - the 3-state enum `decState_t {SEARCH, ACQUIRE, LOCKED}`.
- Sub-module vga_period_meter (instantiated twice: line and frame) provides the edge detect, the saturating counter, and the measured-period latch, with parameterised width.

## Test plan
- Clean 640×480 timing (800×525, negative syncs), starting after reset:
  - locked rises 2 clocks after the 3rd vSync edge;
  - the next frame yields 307200 pixValid cycles with pixX 0..639 and pixY 0..479;
  - exactly 1 frameStart and 480 lineStart pulses.
- RGB driven as {x[3:0], y[3:0], x[7:4]} → each output pixel equals its coordinates, 2 clocks after the pins.
- Locked, then one line shortened to 799 clocks → hTotalMeas = 799 at the next hSync edge, timingErr pulses once, locked falls, relock after 2 good frames.
- Frame length 524 lines during ACQUIRE → goodCnt cleared, locked stays low, lock delayed by one frame.
- hSync held inactive for 2100 clocks → saturation, state returns to SEARCH, hTotalMeas = 2047 not reported as a line.
- nrst pulsed low mid-line while locked → all outputs 0 immediately, no pixValid until 2 good frames complete.
